iomem_arbiter: RTL

//  Shares the single iomem slave port of audio_engine between two bus masters:
//  m0 (CPU, picorv32 iomem) and m1 (DMA/loader streaming coef and audio RAM data).

---
 rtl/iomem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/iomem_arbiter.sv
// Round-robin arbiter sharing audio_engine's iomem slave port between the CPU (m0)
// and the DMA/loader (m1), one transaction per grant, with a slave-ready timeout.
module iomem_arbiter #(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    output logic [1:0]  owner,
    output logic [7:0]  err_count
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // State encoding doubles as the owner output.
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY0 = 2'b01, BUSY1 = 2'b10} state_t;

    state_t        state, state_next;
    logic          last, last_next;      // 1: m1 was served last
    logic [TW-1:0] timer, timer_next;
    logic [7:0]    err_next;

    logic          cur_valid;
    logic [3:0]    cur_wstrb;
    logic [31:0]   cur_addr, cur_wdata;
    logic          valid_c, done;
    logic [31:0]   rdata_c;
    logic          at_limit;

    always_ff @(posedge ck) begin
        if (!rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            timer     <= '0;
            err_count <= '0;
        end else begin
            state     <= state_next;
            last      <= last_next;
            timer     <= timer_next;
            err_count <= err_next;
        end
    end

    always_comb begin
        cur_valid = (state == BUSY1) ? m1_valid : m0_valid;
        cur_wstrb = (state == BUSY1) ? m1_wstrb : m0_wstrb;
        cur_addr  = (state == BUSY1) ? m1_addr  : m0_addr;
        cur_wdata = (state == BUSY1) ? m1_wdata : m0_wdata;
        at_limit  = (timer == TW'(TIMEOUT - 1));
    end

    always_comb begin
        state_next = state;
        last_next  = last;
        timer_next = timer;
        err_next   = err_count;
        valid_c    = 1'b0;
        done       = 1'b0;
        rdata_c    = '0;
        s_wstrb    = '0;
        s_addr     = '0;
        s_wdata    = '0;
        case (state)
            IDLE: begin
                if (m0_valid && (!m1_valid || last))
                    state_next = BUSY0;
                else if (m1_valid)
                    state_next = BUSY1;
            end
            BUSY0, BUSY1: begin
                s_wstrb = cur_wstrb;
                s_addr  = cur_addr;
                s_wdata = cur_wdata;
                rdata_c = s_rdata;
                // Abort, completion and timeout all release the port and rotate priority.
                if (!cur_valid || s_ready || at_limit) begin
                    state_next = IDLE;
                    last_next  = (state == BUSY1);
                    timer_next = '0;
                end else begin
                    timer_next = timer + TW'(1);
                end
                if (cur_valid) begin
                    if (s_ready) begin
                        valid_c = 1'b1;
                        done    = 1'b1;
                    end else if (at_limit) begin
                        done    = 1'b1;
                        rdata_c = ERR_DATA;
                        if (err_count != 8'hFF)
                            err_next = err_count + 8'd1;
                    end else begin
                        valid_c = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are held low while reset is asserted.
    assign s_valid  = rst & valid_c;
    assign m0_ready = rst & done & (state == BUSY0);
    assign m1_ready = rst & done & (state == BUSY1);
    assign m0_rdata = (state == BUSY0) ? rdata_c : 32'h0;
    assign m1_rdata = (state == BUSY1) ? rdata_c : 32'h0;
    assign owner    = state;
endmodule
